// File: rtl/processador_onchip_memory_master.sv
// Avalon-MM master for the single-port on-chip RAM: FILL, COPY or SUM over a word range,
// one command at a time, with all slave-facing signals registered.
//
// state   | meaning
// IDLE    | waiting for cmd_start; no bus activity
// FILL_WR | writing the fill pattern at dst, one word per cycle
// RD      | read request at src
// LAT     | read data returning; SUM accumulates here, COPY captures the word
// CP_WR   | writing the captured word at dst
// FIN     | done pulse; back to IDLE next cycle
module processador_onchip_memory_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_start,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_src,
    input  logic [ADDR_W-1:0]     cmd_dst,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [DATA_W-1:0]     cmd_fill,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     checksum,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_chipselect,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic                  avm_clken,
    input  logic [DATA_W-1:0]     avm_readdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL_WR = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_LAT     = 3'd3;
    localparam logic [2:0] S_CP_WR   = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_COPY = 2'd1;
    localparam logic [1:0] OP_SUM  = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    logic [2:0]        state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] fill_q;
    logic              last_word;

    assign last_word = (rem_q == LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            op_q           <= OP_FILL;
            src_q          <= '0;
            dst_q          <= '0;
            rem_q          <= '0;
            fill_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            checksum       <= '0;
            avm_address    <= '0;
            avm_byteenable <= '1;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_clken      <= 1'b0;
        end else begin
            avm_clken <= 1'b1;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        op_q   <= cmd_op;
                        src_q  <= cmd_src;
                        dst_q  <= cmd_dst;
                        rem_q  <= cmd_len;
                        fill_q <= cmd_fill;
                        busy   <= 1'b1;
                        if (cmd_op == OP_SUM) begin
                            checksum <= '0;
                        end
                        if (cmd_len == '0 || cmd_op == OP_NOP) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else if (cmd_op == OP_FILL) begin
                            state          <= S_FILL_WR;
                            avm_chipselect <= 1'b1;
                            avm_write      <= 1'b1;
                            avm_address    <= cmd_dst;
                            avm_writedata  <= cmd_fill;
                        end else begin
                            state          <= S_RD;
                            avm_chipselect <= 1'b1;
                            avm_write      <= 1'b0;
                            avm_address    <= cmd_src;
                        end
                    end
                end

                S_FILL_WR: begin
                    dst_q <= dst_q + ADDR_W'(1);
                    rem_q <= rem_q - LEN_W'(1);
                    if (last_word) begin
                        state          <= S_FIN;
                        done           <= 1'b1;
                        avm_chipselect <= 1'b0;
                        avm_write      <= 1'b0;
                    end else begin
                        avm_address   <= dst_q + ADDR_W'(1);
                        avm_writedata <= fill_q;
                    end
                end

                S_RD: begin
                    state          <= S_LAT;
                    avm_chipselect <= 1'b0;
                    avm_write      <= 1'b0;
                end

                S_LAT: begin
                    if (op_q == OP_SUM) begin
                        checksum <= checksum + avm_readdata;
                        src_q    <= src_q + ADDR_W'(1);
                        rem_q    <= rem_q - LEN_W'(1);
                        if (last_word) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state          <= S_RD;
                            avm_chipselect <= 1'b1;
                            avm_address    <= src_q + ADDR_W'(1);
                        end
                    end else begin
                        // writedata doubles as the captured-word register for COPY
                        state          <= S_CP_WR;
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b1;
                        avm_address    <= dst_q;
                        avm_writedata  <= avm_readdata;
                    end
                end

                S_CP_WR: begin
                    src_q     <= src_q + ADDR_W'(1);
                    dst_q     <= dst_q + ADDR_W'(1);
                    rem_q     <= rem_q - LEN_W'(1);
                    avm_write <= 1'b0;
                    if (last_word) begin
                        state          <= S_FIN;
                        done           <= 1'b1;
                        avm_chipselect <= 1'b0;
                    end else begin
                        state          <= S_RD;
                        avm_chipselect <= 1'b1;
                        avm_address    <= src_q + ADDR_W'(1);
                    end
                end

                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state          <= S_IDLE;
                    busy           <= 1'b0;
                    avm_chipselect <= 1'b0;
                    avm_write      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_processador_onchip_memory_master.sv
// Bench for processador_onchip_memory_master: a 1024x32 latency-1 RAM slave plus a word-array
// reference model; directed cases followed by randomized commands.
module tb_processador_onchip_memory_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [9:0]  cmd_src = '0;
    logic [9:0]  cmd_dst = '0;
    logic [10:0] cmd_len = '0;
    logic [31:0] cmd_fill = '0;
    logic        busy, done;
    logic [31:0] checksum;
    logic [9:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect, avm_write, avm_clken;
    logic [31:0] avm_writedata;
    bit   [31:0] avm_readdata;

    processador_onchip_memory_master dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .busy(busy), .done(done), .checksum(checksum),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_clken(avm_clken), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    bit [31:0] ram     [0:1023];
    bit [31:0] ref_mem [0:1023];
    bit [9:0]  wlog    [0:4095];
    int cs_cnt = 0, wr_cnt = 0, bad_wr = 0, bad_be = 0;
    int n_vec = 0, n_err = 0;
    bit [31:0] model_ck = 0;

    // RAM slave: address/write sampled at the edge, readdata valid the following cycle
    always @(posedge clk) begin
        if (reset_n) begin
            if (avm_chipselect) begin
                cs_cnt++;
                if (avm_write) begin
                    ram[avm_address] <= avm_writedata;
                    wlog[wr_cnt[11:0]] = avm_address;
                    wr_cnt++;
                end else begin
                    avm_readdata <= ram[avm_address];
                end
            end
            if (avm_write && !avm_chipselect) bad_wr++;
            if (avm_byteenable !== 4'hF) bad_be++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
        check({tag, "_mem"}, bad, 0);
    endtask

    task automatic run_cmd(input bit [1:0] op, input bit [9:0] src, input bit [9:0] dst,
                           input bit [10:0] len, input bit [31:0] fill, input bit inject,
                           input string tag);
        int exp_cyc, exp_cs, exp_wr, cyc, dn, dcyc, cs0, wr0;
        bit [31:0] s;
        // reference: cycle cost from throughput rules, memory effects word by word ascending
        if (len == 0 || op == 2'd3) exp_cyc = 1;
        else if (op == 2'd0) exp_cyc = len + 1;
        else if (op == 2'd2) exp_cyc = 2 * len + 1;
        else exp_cyc = 3 * len + 1;
        exp_cs = (op == 2'd0) ? len : (op == 2'd2) ? len : (op == 2'd1) ? 2 * len : 0;
        exp_wr = (op == 2'd0 || op == 2'd1) ? len : 0;
        s = 0;
        for (int i = 0; i < len; i++) begin
            bit [9:0] a = src + 10'(i);
            bit [9:0] b = dst + 10'(i);
            case (op)
                2'd0: ref_mem[b] = fill;
                2'd1: ref_mem[b] = ref_mem[a];
                2'd2: s += ref_mem[a];
                default: ;
            endcase
        end
        if (op == 2'd2) model_ck = s;
        cs0 = cs_cnt; wr0 = wr_cnt;
        @(negedge clk);
        cmd_start = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill = fill;
        @(negedge clk);
        cmd_start = 1'b0;
        cyc = 0; dn = 0; dcyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            cyc++;
            if (done === 1'b1) begin dn++; dcyc = cyc; end
            if (inject && (cyc == 2 || done === 1'b1)) begin
                cmd_start = 1'b1; cmd_op = 2'd0; cmd_dst = 10'h3A0; cmd_len = 11'd7;
                cmd_fill = 32'hBAD0BAD0;
            end else begin
                cmd_start = 1'b0;
            end
            @(negedge clk);
        end
        cmd_start = 1'b0;
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_done_count"}, dn, 1);
        check({tag, "_done_last"}, dcyc, cyc);
        @(negedge clk);
        check({tag, "_idle"}, {busy, done, avm_chipselect}, 3'b000);
        check({tag, "_cs_cycles"}, cs_cnt - cs0, exp_cs);
        check({tag, "_writes"}, wr_cnt - wr0, exp_wr);
        check({tag, "_checksum"}, checksum, model_ck);
        check_mem(tag);
    endtask

    initial begin
        int w0, k;
        bit [1:0]  rop;
        bit [10:0] rlen;
        bit [31:0] pat;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_bus", {avm_address, avm_chipselect, avm_write}, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_be", avm_byteenable, 4'hF);
        check("rst_clken", avm_clken, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("clken_on", avm_clken, 1);

        w0 = wr_cnt;
        run_cmd(2'd0, 10'h000, 10'h010, 11'd4, 32'hDEADBEEF, 1'b0, "fill4");
        for (int i = 0; i < 4; i++) check("fill4_addr", wlog[12'(w0 + i)], 10'h010 + 10'(i));

        run_cmd(2'd0, 10'h0, 10'h100, 11'd1, 32'h1, 1'b0, "pre0");
        run_cmd(2'd0, 10'h0, 10'h101, 11'd1, 32'h2, 1'b0, "pre1");
        run_cmd(2'd0, 10'h0, 10'h102, 11'd1, 32'hFFFFFFFF, 1'b0, "pre2");
        run_cmd(2'd2, 10'h100, 10'h0, 11'd3, 32'h0, 1'b0, "sum3");
        check("sum3_value", checksum, 32'h00000002);

        run_cmd(2'd1, 10'h010, 10'h200, 11'd4, 32'h0, 1'b1, "copy4_inject");
        check("copy4_word3", ram[10'h203], 32'hDEADBEEF);

        w0 = wr_cnt;
        run_cmd(2'd0, 10'h0, 10'h3FE, 11'd4, 32'h5, 1'b0, "fill_wrap");
        pat = 32'h000003FE;
        for (int i = 0; i < 4; i++) check("fill_wrap_addr", wlog[12'(w0 + i)], 10'(pat + 32'(i)));

        run_cmd(2'd0, 10'h0, 10'h050, 11'd0, 32'h77, 1'b0, "len0");
        run_cmd(2'd3, 10'h010, 10'h050, 11'd5, 32'h77, 1'b0, "nop");
        run_cmd(2'd1, 10'h3FD, 10'h3FE, 11'd6, 32'h0, 1'b0, "copy_smear");

        for (int r = 0; r < 12; r++) begin
            rop  = 2'($urandom_range(0, 3));
            rlen = 11'($urandom_range(0, 40));
            run_cmd(rop, 10'($urandom), 10'($urandom), rlen, $urandom, r[0], "rand");
        end

        pat = $urandom;
        run_cmd(2'd0, 10'($urandom), 10'($urandom), 11'd1024, pat, 1'b0, "fill_all");
        run_cmd(2'd2, 10'($urandom), 10'h0, 11'd1024, 32'h0, 1'b0, "sum_all");
        check("sum_all_value", checksum, pat * 32'd1024);

        run_cmd(2'd0, 10'h0, 10'h010, 11'd4, 32'hA5A50000, 1'b0, "fill_src");
        w0 = wr_cnt;
        @(negedge clk);
        cmd_start = 1'b1; cmd_op = 2'd1; cmd_src = 10'h010; cmd_dst = 10'h280; cmd_len = 11'd4;
        @(negedge clk);
        cmd_start = 1'b0;
        k = 0;
        while (wr_cnt < w0 + 2 && k < 100) begin k++; @(negedge clk); end
        check("abort_reached", wr_cnt - w0, 2);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bus", {avm_chipselect, avm_write}, 2'b00);
        check("abort_checksum", checksum, 0);
        model_ck = 0;
        ref_mem[10'h280] = ref_mem[10'h010];
        ref_mem[10'h281] = ref_mem[10'h011];
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_writes", wr_cnt - w0, 2);
        check_mem("abort");
        run_cmd(2'd2, 10'h27F, 10'h0, 11'd5, 32'h0, 1'b0, "after_abort");

        check("write_without_cs", bad_wr, 0);
        check("byteenable", bad_be, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
